// File: rtl/dmem_responder.sv
// Handshaked RV32 data-memory responder: one request at a time, programmable wait, RV32I byte/half/word access.
// Optional DMEM_STATS_EN adds saturating load/store/error counters (rd_cnt, wr_cnt, err_cnt).
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
`ifdef DMEM_STATS_EN
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
  output logic [15:0] err_cnt,
`endif
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Counter starts at LATENCY so rsp_valid first rises LATENCY+1 edges after acceptance.
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          commit;
  logic          accessErr;
  logic [AW-1:0] idx;
  logic [31:0]   curWord;
  logic [31:0]   newWord;
  logic [31:0]   loadData;
  logic [7:0]    byteVal;
  logic [15:0]   halfVal;

  // Decode the latched request against the addressed word.
  always_comb begin
    idx      = addr_q[AW+1:2];
    curWord  = mem_q[idx];
    byteVal  = curWord[{addr_q[1:0], 3'b000} +: 8];
    halfVal  = addr_q[1] ? curWord[31:16] : curWord[15:0];
    accessErr = 1'b0;
    loadData = 32'd0;
    newWord  = curWord;
    if (addr_q >= 32'(DEPTH_WORDS * 4)) accessErr = 1'b1;
    if (f3_q[1:0] == 2'b01 && addr_q[0]) accessErr = 1'b1;
    if (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) accessErr = 1'b1;
    if (we_q && f3_q > 3'b010) accessErr = 1'b1;
    if (!we_q && (f3_q == 3'b011 || f3_q[2:1] == 2'b11)) accessErr = 1'b1;
    case (f3_q)
      3'b000:  loadData = {{24{byteVal[7]}}, byteVal};
      3'b001:  loadData = {{16{halfVal[15]}}, halfVal};
      3'b010:  loadData = curWord;
      3'b100:  loadData = {24'd0, byteVal};
      3'b101:  loadData = {16'd0, halfVal};
      default: loadData = 32'd0;
    endcase
    case (f3_q)
      3'b000: newWord[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      3'b001: begin
        if (addr_q[1]) newWord[31:16] = wdata_q[15:0];
        else           newWord[15:0]  = wdata_q[15:0];
      end
      3'b010:  newWord = wdata_q;
      default: newWord = curWord;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = LAT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          rdata_d = (accessErr || we_q) ? 32'd0 : loadData;
          err_d   = accessErr;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit && we_q && !accessErr) mem_q[idx] <= newWord;
    end
  end

`ifdef DMEM_STATS_EN
  logic [15:0] rdCnt_q, wrCnt_q, errCnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdCnt_q  <= 16'd0;
      wrCnt_q  <= 16'd0;
      errCnt_q <= 16'd0;
    end else if (commit) begin
      if (accessErr) begin
        if (errCnt_q != 16'hFFFF) errCnt_q <= errCnt_q + 16'd1;
      end else if (we_q) begin
        if (wrCnt_q != 16'hFFFF) wrCnt_q <= wrCnt_q + 16'd1;
      end else begin
        if (rdCnt_q != 16'hFFFF) rdCnt_q <= rdCnt_q + 16'd1;
      end
    end
  end

  assign rd_cnt  = rdCnt_q;
  assign wr_cnt  = wrCnt_q;
  assign err_cnt = errCnt_q;
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
